alarm_setter: RTL and testbench
===============================

ALARM_SETTER -- requirements
Module: alarm_setter

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 25_000_000, cycles an inc/dec button is held before auto-repeat starts (0.5 s at 50 MHz).
REQ-002 SHALL have parameter REPEAT_CYCLES, default 5_000_000, cycles between auto-repeat steps.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 500_000_000, idle cycles after which an edit is abandoned (10 s at 50 MHz).
REQ-004 clk  input  1  single system clock; all logic on its rising edge.
REQ-005 reset  input  1  synchronous, active-low reset (asserted when 0).
REQ-006 btn_mode  input  1  debounced, clk-synchronous level; a press steps through the edit fields.
REQ-007 btn_inc  input  1  debounced level; increments the selected field.
REQ-008 btn_dec  input  1  debounced level; decrements the selected field.
REQ-009 btn_arm  input  1  debounced level; a press toggles arming while not editing.
REQ-010 alarm_hh  output  6  alarm hour, 0-23; feeds the alarm clock's alarm_hh.
REQ-011 alarm_mm  output  6  alarm minute, 0-59.
REQ-012 alarm_ss  output  6  alarm second, 0-59.
REQ-013 set_alarm  output  1  armed level; feeds the alarm clock's set_alarm.
REQ-014 edit_field  output  2  00 none, 01 hh, 10 mm, 11 ss.
REQ-015 editing  output  1  high in any EDIT state.

Function
REQ-016 A press SHALL be a rising edge: the button is sampled 1 while its registered previous sample is 0; outputs SHALL update on that same clock edge.
REQ-017 The FSM SHALL have states IDLE, EDIT_HH, EDIT_MM, EDIT_SS; edit_field and editing SHALL be decoded from the state.
REQ-018 A mode press SHALL step the FSM IDLE->EDIT_HH->EDIT_MM->EDIT_SS->IDLE.
REQ-019 Entering EDIT_HH from IDLE SHALL clear set_alarm.
REQ-020 The EDIT_SS->IDLE transition on a mode press SHALL set set_alarm to 1.
REQ-021 An arm press SHALL toggle set_alarm in IDLE only and SHALL be ignored in EDIT states.
REQ-022 An inc press SHALL add 1 to the selected field; hh wraps 23->0, mm/ss wrap 59->0.
REQ-023 A dec press SHALL subtract 1 from the selected field; hh wraps 0->23, mm/ss wrap 0->59.
REQ-024 Auto-repeat: with t=0 the first high sample, a step SHALL occur at t=0, t=HOLD_CYCLES, then every REPEAT_CYCLES while the button stays high; any low sample SHALL restart the sequence.
REQ-025 If inc and dec are both high in a cycle, no step SHALL occur, and both repeat counters SHALL clear.
REQ-026 If a mode press coincides with an inc/dec step, the mode press SHALL win and the step SHALL be discarded.
REQ-027 inc/dec SHALL be ignored in IDLE; values are held.
REQ-028 In EDIT states, TIMEOUT_CYCLES consecutive cycles with all buttons low SHALL return the FSM to IDLE with set_alarm=0 and field values retained; any button high SHALL reset the timeout counter.
REQ-029 Field registers SHALL never hold out-of-range values; arithmetic SHALL be 6-bit with explicit compare-and-wrap, not modulo of a wider sum.

Reset
REQ-030 When reset=0 at a clock edge, the block SHALL set alarm_hh/mm/ss=0, set_alarm=0, state=IDLE, and clear all counters.
REQ-031 Reset SHALL set the button previous-sample registers to 1, so a button held through reset release produces no press.
REQ-032 Reset SHALL take priority over every press and timeout in the same cycle, including reset asserted mid-edit.

Structure
REQ-033 Package alarm_pkg SHALL hold the state enum, the edit_field codes, and MAX_HOURS=23 and MAX_MINUTES=MAX_SECONDS=59, shared with the alarm clock.
REQ-034 Sub-module button_repeat (rising-edge detect plus hold/repeat counter, parameterised HOLD_CYCLES/REPEAT_CYCLES, output one-cycle step pulse) SHALL be instantiated for inc and dec; mode and arm SHALL use plain edge detect.
REQ-035 Counter widths SHALL be derived with $clog2 from the parameters.

Verification (HOLD_CYCLES=8, REPEAT_CYCLES=4, TIMEOUT_CYCLES=32)
REQ-036 Reset; 1 mode press; 3 inc presses -> alarm_hh=3, edit_field=01, editing=1, set_alarm=0.
REQ-037 In EDIT_HH: hh=23, inc press -> 0; dec press -> 23; in EDIT_MM: mm=59, inc press -> 0; in EDIT_SS: ss=0, dec press -> 59.
REQ-038 In EDIT_SS from ss=0, hold btn_inc for 20 samples -> steps at t=0,8,12,16 -> ss=4; inc+dec both high for 10 cycles -> ss unchanged.
REQ-039 From IDLE: 4 mode presses -> IDLE, set_alarm=1; arm press -> set_alarm=0; arm press -> set_alarm=1; arm press during EDIT_MM -> no change.
REQ-040 1 mode press then 32 idle cycles -> editing=0, edit_field=00, set_alarm=0, values retained; inc and mode pressed in the same cycle -> state advances, value unchanged.
REQ-041 In EDIT_HH at hh=5, assert reset for 1 cycle with btn_inc held through release -> all outputs 0, IDLE, no increment after release.

Source files
------------

// File: rtl/alarm_pkg.sv
// Shared alarm definitions: edit states, field codes, time limits.
// Also holds the wrap-around arithmetic used by the setter.
package alarm_pkg;

    localparam logic [5:0] MAX_HOURS   = 6'd23;
    localparam logic [5:0] MAX_MINUTES = 6'd59;
    localparam logic [5:0] MAX_SECONDS = 6'd59;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_EDIT_HH = 2'b01,
        ST_EDIT_MM = 2'b10,
        ST_EDIT_SS = 2'b11
    } state_t;

    localparam logic [1:0] FIELD_NONE = 2'b00;
    localparam logic [1:0] FIELD_HH   = 2'b01;
    localparam logic [1:0] FIELD_MM   = 2'b10;
    localparam logic [1:0] FIELD_SS   = 2'b11;

    function automatic logic [5:0] inc_wrap(
        input logic [5:0] v,
        input logic [5:0] max
    );
        return (v >= max) ? 6'd0 : v + 6'd1;
    endfunction

    function automatic logic [5:0] dec_wrap(
        input logic [5:0] v,
        input logic [5:0] max
    );
        return (v == 6'd0 || v > max) ? max : v - 6'd1;
    endfunction

    // inc and dec never step together; the repeat units suppress that case
    function automatic logic [5:0] step_field(
        input logic [5:0] v,
        input logic [5:0] max,
        input logic       up,
        input logic       dn
    );
        logic [5:0] r;
        r = v;
        unique case (1'b1)
            up:      r = inc_wrap(v, max);
            dn:      r = dec_wrap(v, max);
            default: r = v;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alarm_setter_button_repeat.sv
// Rising-edge detect plus hold/auto-repeat for one button.
// Emits a one-cycle step at press, after HOLD, then every REPEAT.
module button_repeat #(
    parameter int HOLD_CYCLES   = 25_000_000,
    parameter int REPEAT_CYCLES = 5_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_btn,
    input  logic i_clear,
    output logic o_step
);

    localparam int MAXC = (HOLD_CYCLES > REPEAT_CYCLES) ?
                          HOLD_CYCLES : REPEAT_CYCLES;
    localparam int CW   = (MAXC < 1) ? 1 : $clog2(MAXC + 1);

    logic          r_prev;
    logic          r_rep;
    logic [CW-1:0] r_cnt;

    logic w_rise;
    logic w_active;
    logic w_hold_hit;
    logic w_rep_hit;
    logic w_hit;

    // r_cnt == 0 means no press is being tracked, so a button
    // held through reset never starts a repeat sequence
    assign w_rise     = i_btn & ~r_prev;
    assign w_active   = (r_cnt != '0);
    assign w_hold_hit = ~r_rep & (r_cnt == CW'(HOLD_CYCLES));
    assign w_rep_hit  = r_rep & (r_cnt == CW'(REPEAT_CYCLES));
    assign w_hit      = i_btn & r_prev & w_active &
                        (w_hold_hit | w_rep_hit);
    assign o_step     = ~i_clear & (w_rise | w_hit);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_prev <= 1'b1;
            r_rep  <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_prev <= i_btn;
            if (i_clear || !i_btn) begin
                r_rep <= 1'b0;
                r_cnt <= '0;
            end else if (w_rise) begin
                r_rep <= 1'b0;
                r_cnt <= CW'(1);
            end else if (w_active) begin
                if (w_hold_hit || w_rep_hit) begin
                    r_rep <= 1'b1;
                    r_cnt <= CW'(1);
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/alarm_setter.sv
// Button-driven alarm time editor with arm toggle and edit timeout.
// Fields step through hh/mm/ss on mode presses.
module alarm_setter
    import alarm_pkg::*;
#(
    parameter int HOLD_CYCLES    = 25_000_000,
    parameter int REPEAT_CYCLES  = 5_000_000,
    parameter int TIMEOUT_CYCLES = 500_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_dec,
    input  logic       btn_arm,
    output logic [5:0] alarm_hh,
    output logic [5:0] alarm_mm,
    output logic [5:0] alarm_ss,
    output logic       set_alarm,
    output logic [1:0] edit_field,
    output logic       editing
);

    localparam int TW = (TIMEOUT_CYCLES < 1) ? 1 :
                        $clog2(TIMEOUT_CYCLES + 1);

    state_t        r_state;
    state_t        w_state;
    logic [5:0]    r_hh, r_mm, r_ss;
    logic [5:0]    w_hh, w_mm, w_ss;
    logic          r_set, w_set;
    logic          r_prev_mode, r_prev_arm;
    logic [TW-1:0] r_tcnt;

    logic w_mode_press;
    logic w_arm_press;
    logic w_both;
    logic w_inc_step;
    logic w_dec_step;
    logic w_quiet;
    logic w_timeout;

    assign w_mode_press = btn_mode & ~r_prev_mode;
    assign w_arm_press  = btn_arm & ~r_prev_arm;
    assign w_both       = btn_inc & btn_dec;
    assign w_quiet      = ~(btn_mode | btn_inc | btn_dec | btn_arm);
    assign w_timeout    = (r_state != ST_IDLE) & w_quiet &
                          (r_tcnt == TW'(TIMEOUT_CYCLES - 1));

    button_repeat #(
        .HOLD_CYCLES  (HOLD_CYCLES),
        .REPEAT_CYCLES(REPEAT_CYCLES)
    ) u_inc (
        .clk    (clk),
        .reset  (reset),
        .i_btn  (btn_inc),
        .i_clear(w_both),
        .o_step (w_inc_step)
    );

    button_repeat #(
        .HOLD_CYCLES  (HOLD_CYCLES),
        .REPEAT_CYCLES(REPEAT_CYCLES)
    ) u_dec (
        .clk    (clk),
        .reset  (reset),
        .i_btn  (btn_dec),
        .i_clear(w_both),
        .o_step (w_dec_step)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_hh        <= '0;
            r_mm        <= '0;
            r_ss        <= '0;
            r_set       <= 1'b0;
            r_prev_mode <= 1'b1;
            r_prev_arm  <= 1'b1;
            r_tcnt      <= '0;
        end else begin
            r_state     <= w_state;
            r_hh        <= w_hh;
            r_mm        <= w_mm;
            r_ss        <= w_ss;
            r_set       <= w_set;
            r_prev_mode <= btn_mode;
            r_prev_arm  <= btn_arm;
            if (r_state == ST_IDLE || !w_quiet || w_timeout)
                r_tcnt <= '0;
            else
                r_tcnt <= r_tcnt + TW'(1);
        end
    end

    // mode press outranks any inc/dec step landing in the same cycle
    always_comb begin
        w_state = r_state;
        w_hh    = r_hh;
        w_mm    = r_mm;
        w_ss    = r_ss;
        w_set   = r_set;
        unique case (r_state)
            ST_IDLE: begin
                if (w_mode_press) begin
                    w_state = ST_EDIT_HH;
                    w_set   = 1'b0;
                end else if (w_arm_press) begin
                    w_set = ~r_set;
                end
            end
            ST_EDIT_HH: begin
                if (w_mode_press) begin
                    w_state = ST_EDIT_MM;
                end else if (w_timeout) begin
                    w_state = ST_IDLE;
                    w_set   = 1'b0;
                end else begin
                    w_hh = step_field(r_hh, MAX_HOURS,
                                      w_inc_step, w_dec_step);
                end
            end
            ST_EDIT_MM: begin
                if (w_mode_press) begin
                    w_state = ST_EDIT_SS;
                end else if (w_timeout) begin
                    w_state = ST_IDLE;
                    w_set   = 1'b0;
                end else begin
                    w_mm = step_field(r_mm, MAX_MINUTES,
                                      w_inc_step, w_dec_step);
                end
            end
            ST_EDIT_SS: begin
                if (w_mode_press) begin
                    w_state = ST_IDLE;
                    w_set   = 1'b1;
                end else if (w_timeout) begin
                    w_state = ST_IDLE;
                    w_set   = 1'b0;
                end else begin
                    w_ss = step_field(r_ss, MAX_SECONDS,
                                      w_inc_step, w_dec_step);
                end
            end
            default: w_state = ST_IDLE;
        endcase
    end

    always_comb begin
        edit_field = FIELD_NONE;
        editing    = 1'b0;
        unique case (r_state)
            ST_EDIT_HH: begin
                edit_field = FIELD_HH;
                editing    = 1'b1;
            end
            ST_EDIT_MM: begin
                edit_field = FIELD_MM;
                editing    = 1'b1;
            end
            ST_EDIT_SS: begin
                edit_field = FIELD_SS;
                editing    = 1'b1;
            end
            default: begin
                edit_field = FIELD_NONE;
                editing    = 1'b0;
            end
        endcase
    end

    assign alarm_hh  = r_hh;
    assign alarm_mm  = r_mm;
    assign alarm_ss  = r_ss;
    assign set_alarm = r_set;

endmodule

// File: tb/tb_alarm_setter.sv
// Directed self-checking bench for alarm_setter.
// Small timing parameters keep the repeat and timeout runs short.
module tb_alarm_setter;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_mode, btn_inc, btn_dec, btn_arm;
    logic [5:0] alarm_hh, alarm_mm, alarm_ss;
    logic       set_alarm;
    logic [1:0] edit_field;
    logic       editing;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alarm_setter #(
        .HOLD_CYCLES   (8),
        .REPEAT_CYCLES (4),
        .TIMEOUT_CYCLES(32)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_mode  (btn_mode),
        .btn_inc   (btn_inc),
        .btn_dec   (btn_dec),
        .btn_arm   (btn_arm),
        .alarm_hh  (alarm_hh),
        .alarm_mm  (alarm_mm),
        .alarm_ss  (alarm_ss),
        .set_alarm (set_alarm),
        .edit_field(edit_field),
        .editing   (editing)
    );

    typedef struct packed {
        logic       mode;
        logic       inc;
        logic       dec;
        logic       arm;
        logic [5:0] hh;
        logic [5:0] mm;
        logic [5:0] ss;
        logic       set;
        logic [1:0] fld;
        logic       ed;
    } vec_t;

    localparam int NV = 28;
    vec_t vecs [NV];

    function automatic vec_t mk(
        input logic m, input logic i, input logic d, input logic a,
        input int hh, input int mm, input int ss,
        input logic s, input int f, input logic e
    );
        vec_t v;
        v.mode = m;
        v.inc  = i;
        v.dec  = d;
        v.arm  = a;
        v.hh   = 6'(hh);
        v.mm   = 6'(mm);
        v.ss   = 6'(ss);
        v.set  = s;
        v.fld  = 2'(f);
        v.ed   = e;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string nm,
                           input int hh, input int mm, input int ss,
                           input logic s, input int f, input logic e);
        chk({nm, "_hh"},  32'(alarm_hh),   32'(hh));
        chk({nm, "_mm"},  32'(alarm_mm),   32'(mm));
        chk({nm, "_ss"},  32'(alarm_ss),   32'(ss));
        chk({nm, "_set"}, 32'(set_alarm),  32'(s));
        chk({nm, "_fld"}, 32'(edit_field), 32'(f));
        chk({nm, "_ed"},  32'(editing),    32'(e));
    endtask

    task automatic release_all();
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        btn_dec  = 1'b0;
        btn_arm  = 1'b0;
    endtask

    task automatic press_mode();
        btn_mode = 1'b1;
        tick();
        btn_mode = 1'b0;
        tick();
    endtask

    int exp_ss;

    initial begin
        //           m  i  d  a  hh  mm  ss set f  ed
        vecs[0]  = mk(1, 0, 0, 0,  0,  0,  0, 0, 1, 1);
        vecs[1]  = mk(0, 1, 0, 0,  1,  0,  0, 0, 1, 1);
        vecs[2]  = mk(0, 1, 0, 0,  2,  0,  0, 0, 1, 1);
        vecs[3]  = mk(0, 1, 0, 0,  3,  0,  0, 0, 1, 1);
        vecs[4]  = mk(0, 0, 1, 0,  2,  0,  0, 0, 1, 1);
        vecs[5]  = mk(0, 0, 1, 0,  1,  0,  0, 0, 1, 1);
        vecs[6]  = mk(0, 0, 1, 0,  0,  0,  0, 0, 1, 1);
        vecs[7]  = mk(0, 0, 1, 0, 23,  0,  0, 0, 1, 1);
        vecs[8]  = mk(0, 1, 0, 0,  0,  0,  0, 0, 1, 1);
        vecs[9]  = mk(0, 0, 1, 0, 23,  0,  0, 0, 1, 1);
        vecs[10] = mk(0, 0, 0, 1, 23,  0,  0, 0, 1, 1);
        vecs[11] = mk(1, 0, 0, 0, 23,  0,  0, 0, 2, 1);
        vecs[12] = mk(0, 0, 1, 0, 23, 59,  0, 0, 2, 1);
        vecs[13] = mk(0, 1, 0, 0, 23,  0,  0, 0, 2, 1);
        vecs[14] = mk(0, 0, 1, 0, 23, 59,  0, 0, 2, 1);
        vecs[15] = mk(0, 1, 0, 0, 23,  0,  0, 0, 2, 1);
        vecs[16] = mk(0, 0, 0, 1, 23,  0,  0, 0, 2, 1);
        vecs[17] = mk(1, 0, 0, 0, 23,  0,  0, 0, 3, 1);
        vecs[18] = mk(0, 0, 1, 0, 23,  0, 59, 0, 3, 1);
        vecs[19] = mk(0, 1, 0, 0, 23,  0,  0, 0, 3, 1);
        vecs[20] = mk(1, 0, 0, 0, 23,  0,  0, 1, 0, 0);
        vecs[21] = mk(0, 0, 0, 1, 23,  0,  0, 0, 0, 0);
        vecs[22] = mk(0, 0, 0, 1, 23,  0,  0, 1, 0, 0);
        vecs[23] = mk(0, 1, 0, 0, 23,  0,  0, 1, 0, 0);
        vecs[24] = mk(0, 0, 1, 0, 23,  0,  0, 1, 0, 0);
        vecs[25] = mk(1, 1, 0, 0, 23,  0,  0, 0, 1, 1);
        vecs[26] = mk(1, 0, 1, 0, 23,  0,  0, 0, 2, 1);
        vecs[27] = mk(1, 1, 0, 0, 23,  0,  0, 0, 3, 1);

        release_all();
        reset = 1'b0;
        ticks(2);
        chk_all("reset", 0, 0, 0, 1'b0, 0, 1'b0);
        reset = 1'b1;
        tick();

        for (int i = 0; i < NV; i++) begin
            btn_mode = vecs[i].mode;
            btn_inc  = vecs[i].inc;
            btn_dec  = vecs[i].dec;
            btn_arm  = vecs[i].arm;
            tick();
            chk_all($sformatf("vec%0d", i),
                    int'(vecs[i].hh), int'(vecs[i].mm),
                    int'(vecs[i].ss), vecs[i].set,
                    int'(vecs[i].fld), vecs[i].ed);
            release_all();
            tick();
        end

        // EDIT_SS, ss=0: hold inc 20 samples, steps at t=0,8,12,16
        btn_inc = 1'b1;
        for (int t = 0; t < 20; t++) begin
            tick();
            exp_ss = 1 + int'(t >= 8) + int'(t >= 12) + int'(t >= 16);
            chk($sformatf("hold_t%0d_ss", t), 32'(alarm_ss),
                32'(exp_ss));
        end
        btn_inc = 1'b0;
        tick();
        chk("hold_final_ss", 32'(alarm_ss), 32'd4);

        btn_inc = 1'b1;
        btn_dec = 1'b1;
        ticks(10);
        chk("both_ss", 32'(alarm_ss), 32'd4);
        chk("both_fld", 32'(edit_field), 32'd3);
        release_all();
        tick();

        // edit timeout after 32 quiet cycles
        press_mode();
        chk("to_idle_set", 32'(set_alarm), 32'd1);
        btn_mode = 1'b1;
        tick();
        btn_mode = 1'b0;
        chk("to_enter_fld", 32'(edit_field), 32'd1);
        ticks(31);
        chk("to_31_ed", 32'(editing), 32'd1);
        tick();
        chk_all("to_32", 23, 0, 4, 1'b0, 0, 1'b0);

        // reset mid-edit with inc held through release
        press_mode();
        for (int k = 0; k < 6; k++) begin
            btn_inc = 1'b1;
            tick();
            btn_inc = 1'b0;
            tick();
        end
        chk("pre_rst_hh", 32'(alarm_hh), 32'd5);
        chk("pre_rst_fld", 32'(edit_field), 32'd1);
        reset   = 1'b0;
        btn_inc = 1'b1;
        tick();
        chk_all("rst_mid", 0, 0, 0, 1'b0, 0, 1'b0);
        reset = 1'b1;
        ticks(12);
        chk_all("rst_rel", 0, 0, 0, 1'b0, 0, 1'b0);
        btn_mode = 1'b1;
        tick();
        btn_mode = 1'b0;
        ticks(10);
        chk_all("rst_held", 0, 0, 0, 1'b0, 1, 1'b1);
        release_all();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
